// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE core: hash mode, rate sizes and
// the output-side controller state encoding.
package shake_pkg;

  typedef enum logic {
    SHAKE128 = 1'b0,
    SHAKE256 = 1'b1
  } mode_t;

  localparam int unsigned RATE128_WORDS = 21;
  localparam int unsigned RATE256_WORDS = 17;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLOCK = 2'd1,
    DUMP       = 2'd2
  } state_t;

endpackage

// File: rtl/dump_fsm_output_piso.sv
// Parallel-in/serial-out word buffer for one squeezed rate block.
// Shifting moves word 1 into word 0 and fills the top word with zeros.
module output_piso #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 21
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [DEPTH*W-1:0] din,
  output logic [W-1:0]     word0
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= din[i*W +: W];
    end else if (shift) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
    end
  end

  assign word0 = mem[0];

endmodule

// File: rtl/dump_fsm.sv
// SHAKE output controller: streams squeezed rate blocks as W-bit words until
// the requested length is exhausted. Define DUMP_MASK_TAIL_EN to zero the
// unused bits of a partial final word.
module dump_fsm
  import shake_pkg::*;
#(
  parameter int unsigned W              = 64,
  parameter int unsigned MAX_RATE_WORDS = 21,
  parameter int unsigned LEN_W          = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  output logic                        start_ready_o,
  input  logic [LEN_W-1:0]            output_length_i,
  input  logic                        mode_i,
  input  logic                        block_valid_i,
  input  logic [MAX_RATE_WORDS*W-1:0] block_i,
  output logic                        block_ready_o,
  output logic                        squeeze_request_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [W-1:0]                data_o,
  output logic                        last_o,
  output logic                        done_o
);

  localparam int unsigned CNT_W = $clog2(MAX_RATE_WORDS + 1);

  state_t           state;
  mode_t            mode;
  logic [LEN_W-1:0] remaining;
  logic [CNT_W-1:0] word_cnt;
  logic [W-1:0]     raw_word;
  logic             is_last;

  assign start_ready_o = (state == IDLE);
  assign block_ready_o = (state == WAIT_BLOCK);
  assign valid_o       = (state == DUMP);
  assign is_last       = (remaining <= LEN_W'(W));
  assign last_o        = valid_o && is_last;

  output_piso #(
    .W     (W),
    .DEPTH (MAX_RATE_WORDS)
  ) u_piso (
    .clk   (clk),
    .clr   (rst),
    .load  (block_ready_o && block_valid_i),
    .shift (valid_o && ready_i),
    .din   (block_i),
    .word0 (raw_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      mode              <= SHAKE128;
      remaining         <= '0;
      word_cnt          <= '0;
      done_o            <= 1'b0;
      squeeze_request_o <= 1'b0;
    end else begin
      done_o            <= 1'b0;
      squeeze_request_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            mode      <= mode_t'(mode_i);
            remaining <= output_length_i;
            if (output_length_i == '0) done_o <= 1'b1;
            else                       state  <= WAIT_BLOCK;
          end
        end
        WAIT_BLOCK: begin
          if (block_valid_i) begin
            word_cnt <= (mode == SHAKE256) ? CNT_W'(RATE256_WORDS) : CNT_W'(RATE128_WORDS);
            state    <= DUMP;
          end
        end
        DUMP: begin
          if (ready_i) begin
            word_cnt  <= word_cnt - CNT_W'(1);
            // remaining <= W covers the saturating case of the subtraction
            remaining <= is_last ? '0 : remaining - LEN_W'(W);
            if (is_last) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end else if (word_cnt == CNT_W'(1)) begin
              squeeze_request_o <= 1'b1;
              state             <= WAIT_BLOCK;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUMP_MASK_TAIL_EN
  localparam int unsigned   TAIL_W   = $clog2(W);
  localparam logic [W-1:0]  ALL_ONES = '1;
  logic [TAIL_W-1:0] tail;

  assign tail = remaining[TAIL_W-1:0];

  always_comb begin
    data_o = raw_word;
    if (last_o && tail != '0) data_o = raw_word & ~(ALL_ONES << tail);
  end
`else
  assign data_o = raw_word;
`endif

endmodule
